// File: rtl/command_tag_tracker_pkg.sv
// command_tag_tracker_pkg: shared types and defaults for the PSL command tag tracker.
package command_tag_tracker_pkg;

    localparam int NUM_TAGS_DEF = 32;
    localparam int TAG_W_DEF    = 8;

    typedef enum logic [12:0] {
        CMD_READ_CL_NA = 13'h0A00,
        CMD_READ_CL_S  = 13'h0A50,
        CMD_WRITE_NA   = 13'h0D00,
        CMD_WRITE_MI   = 13'h0D60
    } psl_cmd_e;

    typedef enum logic [7:0] {
        RSP_DONE    = 8'h00,
        RSP_AERROR  = 8'h01,
        RSP_DERROR  = 8'h03,
        RSP_NLOCK   = 8'h04,
        RSP_NRES    = 8'h05,
        RSP_FLUSHED = 8'h06,
        RSP_FAULT   = 8'h07,
        RSP_FAILED  = 8'h08,
        RSP_PAGED   = 8'h0A
    } psl_rsp_e;

    typedef logic [1:0] tracker_state_t;
    localparam tracker_state_t ST_IDLE  = 2'd0;
    localparam tracker_state_t ST_LOAD  = 2'd1;
    localparam tracker_state_t ST_RUN   = 2'd2;
    localparam tracker_state_t ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [7:0]  id;
        logic [12:0] cmd;
    } tag_meta_t;

endpackage

// File: rtl/command_tag_tracker_tag_allocator.sv
// tag_allocator: busy bitmap with lowest-free-tag priority encoder and busy lookup.
module tag_allocator #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_avail,
    input  logic             free_en,
    input  logic [TAG_W-1:0] free_tag,
    input  logic [TAG_W-1:0] chk_tag,
    output logic             is_busy
);

    localparam int IW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [TAG_W:0] NT = NUM_TAGS[TAG_W:0];

    logic [NUM_TAGS-1:0] busy_q, busy_d;

    // Allocation always reads the registered bitmap, so a tag freed this cycle is not reissued until next cycle.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            alloc_tag = busy_q[i] ? alloc_tag : i[TAG_W-1:0];
        busy_d = busy_q;
        if (alloc_en)
            busy_d[alloc_tag[IW-1:0]] = 1'b1;
        if (free_en)
            busy_d[free_tag[IW-1:0]] = 1'b0;
    end

    assign alloc_avail = ~&busy_q;
    assign is_busy     = ({1'b0, chk_tag} < NT) && busy_q[chk_tag[IW-1:0]];

    always_ff @(posedge clock or posedge reset)
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;

endmodule

// File: rtl/command_tag_tracker.sv
// command_tag_tracker: issues arbitrated commands to PSL with a free tag under credit limits,
// and retires PSL responses back to the originating requester.
module command_tag_tracker
    import command_tag_tracker_pkg::*;
#(
    parameter int NUM_TAGS       = NUM_TAGS_DEF,
    parameter int TAG_W          = TAG_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enabled_in,
    input  logic [7:0]       room_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [12:0]      req_cmd,
    input  logic [63:0]      req_addr,
    input  logic [11:0]      req_size,
    input  logic [7:0]       req_id,
    output logic             psl_valid,
    output logic [TAG_W-1:0] psl_tag,
    output logic [12:0]      psl_cmd,
    output logic [63:0]      psl_addr,
    output logic [11:0]      psl_size,
    input  logic             rsp_valid,
    input  logic [TAG_W-1:0] rsp_tag,
    input  logic [7:0]       rsp_code,
    output logic             done_valid,
    output logic [7:0]       done_id,
    output logic [12:0]      done_cmd,
    output logic [7:0]       done_code,
    output logic [8:0]       outstanding,
    output logic             tag_error,
    output logic             timeout_error,
    input  logic             err_clear
);

    localparam int IW   = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = TIMEOUT_CYCLES[WD_W-1:0];
    localparam logic [8:0]      NT9    = NUM_TAGS[8:0];

    tracker_state_t   state_q, state_d;
    logic [8:0]       credits_q, credits_d, outs_q, outs_d, room9;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             accept, rsp_ok, rsp_bad, wd_hit, alloc_avail, tag_busy;
    logic [TAG_W-1:0] alloc_tag;
    tag_meta_t        meta_q [NUM_TAGS];
    tag_meta_t        rd_meta;

    tag_allocator #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_alloc (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (accept),
        .alloc_tag   (alloc_tag),
        .alloc_avail (alloc_avail),
        .free_en     (rsp_ok),
        .free_tag    (rsp_tag),
        .chk_tag     (rsp_tag),
        .is_busy     (tag_busy)
    );

    assign req_ready   = state_q == ST_RUN && credits_q != '0 && alloc_avail;
    assign accept      = req_valid && req_ready;
    assign rsp_ok      = rsp_valid && tag_busy;
    assign rsp_bad     = rsp_valid && !tag_busy;
    assign room9       = {1'b0, room_in};
    assign rd_meta     = meta_q[rsp_tag[IW-1:0]];
    assign outstanding = outs_q;
    assign wd_hit      = wd_d == WD_MAX && wd_q != WD_MAX;

    always_comb begin
        state_d   = state_q == ST_IDLE ? (enabled_in ? ST_LOAD : ST_IDLE) :
                    state_q == ST_LOAD ? ST_RUN :
                    state_q == ST_RUN  ? (enabled_in ? ST_RUN : ST_DRAIN) :
                    (outs_q == '0 ? ST_IDLE : ST_DRAIN);
        credits_d = state_q == ST_LOAD ? (room9 < NT9 ? room9 : NT9) :
                    (state_q == ST_DRAIN && outs_q == '0) ? '0 :
                    credits_q - {8'd0, accept} + {8'd0, rsp_ok};
        outs_d    = outs_q + {8'd0, accept} - {8'd0, rsp_ok};
        wd_d      = (outs_q == '0 || rsp_valid) ? '0 :
                    (wd_q == WD_MAX ? wd_q : wd_q + WD_W'(1));
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q       <= ST_IDLE;
            credits_q     <= '0;
            outs_q        <= '0;
            wd_q          <= '0;
            psl_valid     <= 1'b0;
            psl_tag       <= '0;
            psl_cmd       <= '0;
            psl_addr      <= '0;
            psl_size      <= '0;
            done_valid    <= 1'b0;
            done_id       <= '0;
            done_cmd      <= '0;
            done_code     <= '0;
            tag_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            credits_q     <= credits_d;
            outs_q        <= outs_d;
            wd_q          <= wd_d;
            psl_valid     <= accept;
            done_valid    <= rsp_ok;
            // A fresh error in the same cycle as err_clear keeps the flag set.
            tag_error     <= rsp_bad || (tag_error && !err_clear);
            timeout_error <= wd_hit || (timeout_error && !err_clear);
            if (accept) begin
                psl_tag  <= alloc_tag;
                psl_cmd  <= req_cmd;
                psl_addr <= req_addr;
                psl_size <= req_size;
            end
            if (rsp_ok) begin
                done_id   <= rd_meta.id;
                done_cmd  <= rd_meta.cmd;
                done_code <= rsp_code;
            end
        end

    always_ff @(posedge clock)
        if (accept)
            meta_q[alloc_tag[IW-1:0]] <= '{id: req_id, cmd: req_cmd};

endmodule

// File: tb/tb_command_tag_tracker.sv
// tb_command_tag_tracker: directed vectors with hand-computed expectations for the tag tracker.
module tb_command_tag_tracker;
    import command_tag_tracker_pkg::*;

    logic        clock = 1'b0, reset = 1'b1, enabled_in = 1'b0, err_clear = 1'b0;
    logic [7:0]  room_in = '0, req_id = '0, rsp_code = '0, rsp_tag = '0;
    logic        req_valid = 1'b0, rsp_valid = 1'b0;
    logic [12:0] req_cmd = '0;
    logic [63:0] req_addr = '0;
    logic [11:0] req_size = '0;
    logic        req_ready, psl_valid, done_valid, tag_error, timeout_error;
    logic [7:0]  psl_tag, done_id, done_code;
    logic [12:0] psl_cmd, done_cmd;
    logic [63:0] psl_addr;
    logic [11:0] psl_size;
    logic [8:0]  outstanding;

    int vectors = 0, miscompares = 0;

    logic [7:0] t4_tag [4] = '{8'd1, 8'd5, 8'd6, 8'd7};
    logic [7:0] rt_tag [5] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [7:0] rt_id  [5] = '{8'h30, 8'h32, 8'h33, 8'h34, 8'h41};
    logic [7:0] dr_tag [3] = '{8'd1, 8'd6, 8'd7};
    logic [7:0] dr_id  [3] = '{8'h40, 8'h42, 8'h43};

    command_tag_tracker #(.NUM_TAGS(32), .TAG_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .enabled_in(enabled_in), .room_in(room_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_size(req_size), .req_id(req_id),
        .psl_valid(psl_valid), .psl_tag(psl_tag), .psl_cmd(psl_cmd), .psl_addr(psl_addr),
        .psl_size(psl_size),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
        .done_valid(done_valid), .done_id(done_id), .done_cmd(done_cmd), .done_code(done_code),
        .outstanding(outstanding), .tag_error(tag_error), .timeout_error(timeout_error),
        .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic go_run(input logic [7:0] room);
        enabled_in = 1'b1;
        room_in    = room;
        step();
        step();
    endtask

    task automatic issue(input logic [7:0] id, input logic exp_rdy, input logic [7:0] exp_tag);
        req_valid = 1'b1;
        req_id    = id;
        req_cmd   = {5'h0A, id};
        req_addr  = {49'h0, id, 7'h0};
        req_size  = 12'd128;
        check("req_ready", req_ready, exp_rdy);
        step();
        req_valid = 1'b0;
        check("psl_valid", psl_valid, exp_rdy);
        if (exp_rdy) begin
            check("psl_tag", psl_tag, exp_tag);
            check("psl_cmd", psl_cmd, {5'h0A, id});
            check("psl_addr", psl_addr, {49'h0, id, 7'h0});
        end
    endtask

    task automatic respond(input logic [7:0] tag, input logic [7:0] code);
        rsp_valid = 1'b1;
        rsp_tag   = tag;
        rsp_code  = code;
        step();
        rsp_valid = 1'b0;
    endtask

    task automatic done_chk(input logic [7:0] id, input logic [7:0] code);
        check("done_valid", done_valid, 1'b1);
        check("done_id", done_id, id);
        check("done_cmd", done_cmd, {5'h0A, id});
        check("done_code", done_code, code);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        step();
        step();
        check("rst_outstanding", outstanding, 0);
        check("rst_psl_valid", psl_valid, 0);
        check("rst_psl_tag", psl_tag, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_tag_error", tag_error, 0);
        check("rst_timeout_error", timeout_error, 0);
        check("rst_req_ready", req_ready, 0);
        reset = 1'b0;
        step();
        check("idle_req_ready", req_ready, 0);

        // room 4, six back-to-back requests: only the first four get tags 0..3
        go_run(8'd4);
        for (int i = 0; i < 6; i++)
            issue(8'h10 + i[7:0], i < 4, i[7:0]);
        check("t1_outstanding", outstanding, 4);
        check("t1_req_ready", req_ready, 0);

        respond(8'd2, RSP_DONE);
        done_chk(8'h12, RSP_DONE);
        check("t2_outstanding_a", outstanding, 3);
        respond(8'd0, RSP_DONE);
        done_chk(8'h10, RSP_DONE);
        check("t2_outstanding_b", outstanding, 2);
        issue(8'h20, 1'b1, 8'd0);
        check("t2_done_idle", done_valid, 0);
        check("t2_outstanding_c", outstanding, 3);

        respond(8'd7, RSP_DERROR);
        check("t3_tag_error", tag_error, 1);
        check("t3_no_done", done_valid, 0);
        check("t3_outstanding", outstanding, 3);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("t3_cleared", tag_error, 0);
        respond(8'd40, RSP_DONE);
        check("t3_range_error", tag_error, 1);
        err_clear = 1'b1;
        respond(8'd40, RSP_DONE);
        err_clear = 1'b0;
        check("t3_new_wins", tag_error, 1);
        check("t3_outstanding_b", outstanding, 3);
        check("t3_no_timeout", timeout_error, 0);

        // asynchronous reset while running with work in flight
        reset = 1'b1;
        #1;
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_tag_error", tag_error, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_psl_valid", psl_valid, 0);
        check("mid_rst_psl_tag", psl_tag, 0);
        check("mid_rst_done_valid", done_valid, 0);
        enabled_in = 1'b0;
        step();
        reset = 1'b0;
        step();

        // same-cycle accept and response on tag 1 with tags 0..3 busy
        go_run(8'd8);
        for (int i = 0; i < 4; i++)
            issue(8'h30 + i[7:0], 1'b1, i[7:0]);
        rsp_valid = 1'b1;
        rsp_tag   = 8'd1;
        rsp_code  = RSP_FAULT;
        issue(8'h34, 1'b1, 8'd4);
        rsp_valid = 1'b0;
        done_chk(8'h31, RSP_FAULT);
        check("t4_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++)
            issue(8'h40 + i[7:0], 1'b1, t4_tag[i]);
        check("t4_credits_spent", req_ready, 0);
        check("t4_outstanding_b", outstanding, 8);

        for (int i = 0; i < 5; i++) begin
            respond(rt_tag[i], RSP_PAGED);
            done_chk(rt_id[i], RSP_PAGED);
        end
        check("t6_outstanding", outstanding, 3);

        // disable with three in flight: no accepts, responses still retire
        enabled_in = 1'b0;
        step();
        req_valid = 1'b1;
        check("t6_drain_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            respond(dr_tag[i], RSP_FLUSHED);
            done_chk(dr_id[i], RSP_FLUSHED);
            check("t6_no_issue", psl_valid, 0);
        end
        req_valid = 1'b0;
        check("t6_drained", outstanding, 0);
        step();
        go_run(8'd2);
        issue(8'h50, 1'b1, 8'd0);
        issue(8'h51, 1'b1, 8'd1);
        issue(8'h52, 1'b0, 8'd0);

        // watchdog with TIMEOUT_CYCLES=16
        reset      = 1'b1;
        enabled_in = 1'b0;
        step();
        reset = 1'b0;
        step();
        go_run(8'd4);
        issue(8'h60, 1'b1, 8'd0);
        for (int k = 0; k < 15; k++)
            step();
        check("t5_before_timeout", timeout_error, 0);
        step();
        check("t5_timeout", timeout_error, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("t5_timeout_cleared", timeout_error, 0);
        respond(8'd0, RSP_DONE);
        done_chk(8'h60, RSP_DONE);
        check("t5_outstanding", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
